// File: rtl/ht_pkg.sv
// Shared types and constants for the ht sequencing controller.
package ht_pkg;

    typedef enum logic [1:0] {LOAD, START, RUN, DRAIN} ht_ctrl_state_t;

    localparam int JOB_CNT_W     = 16;
    localparam int WIDTH_DEFAULT = 5;

endpackage

// File: rtl/ht_ctrl_wdog.sv
// RUN-state watchdog: counts cycles while clear is low and flags expiry
// on the cycle the count reaches timeout-1 (the timeout-th RUN cycle).
module ht_ctrl_wdog #(
    parameter int timeout = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int WD_W = $clog2(timeout + 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign expired = !clear && (wd_cnt == WD_W'(timeout - 1));

endmodule

// File: rtl/ht_ctrl.sv
// Serial-in / serial-out sequencer around one ht core.
// Optional RUN watchdog enabled by defining HT_CTRL_TIMEOUT_EN.
module ht_ctrl
    import ht_pkg::*;
#(
    parameter int index   = 8,
    parameter int width   = WIDTH_DEFAULT,
    parameter int timeout = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [width-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [width-1:0]         out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     ht_start,
    output logic [index*width-1:0]   ht_indata,
    input  logic [index*width-1:0]   ht_outdata,
    input  logic                     ht_over,
    output logic                     busy,
    output logic [JOB_CNT_W-1:0]     job_cnt,
    output logic                     err
);

    localparam int CNT_W = $clog2(index);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(index - 1);

    ht_ctrl_state_t state, state_next;

    logic [CNT_W-1:0]       cnt;
    logic [index*width-1:0] in_buf;
    logic [index*width-1:0] res_buf;
    logic [JOB_CNT_W-1:0]   jobs;
    logic                   in_acc, out_acc, cap, abort;
    logic                   wd_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_acc     = 1'b0;
        out_acc    = 1'b0;
        cap        = 1'b0;
        abort      = 1'b0;
        unique case (state)
            LOAD: begin
                if (in_valid) begin
                    in_acc = 1'b1;
                    if (cnt == CNT_LAST) state_next = START;
                end
            end
            START: state_next = RUN;
            RUN: begin
                // ht_over has priority over a watchdog expiry in the same cycle
                if (ht_over) begin
                    cap        = 1'b1;
                    state_next = DRAIN;
                end else if (wd_expired) begin
                    abort      = 1'b1;
                    state_next = LOAD;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    out_acc = 1'b1;
                    if (cnt == CNT_LAST) state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            in_buf  <= '0;
            res_buf <= '0;
            jobs    <= '0;
        end else begin
            if (in_acc) begin
                in_buf[cnt*width +: width] <= in_data;
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            if (cap) begin
                res_buf <= ht_outdata;
                cnt     <= '0;
            end
            if (abort) begin
                res_buf <= '0;
                cnt     <= '0;
            end
            if (out_acc) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                if (cnt == CNT_LAST) jobs <= jobs + 1'b1;
            end
        end
    end

`ifdef HT_CTRL_TIMEOUT_EN
    logic err_q;

    ht_ctrl_wdog #(.timeout(timeout)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != RUN),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = timeout[0];
    assign wd_expired     = 1'b0;
    assign err            = 1'b0;
`endif

    assign in_ready  = (state == LOAD) && !rst;
    assign ht_start  = (state == START);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (cnt == CNT_LAST);
    assign out_data  = res_buf[cnt*width +: width];
    assign ht_indata = in_buf;
    assign busy      = (state != LOAD);
    assign job_cnt   = jobs;

endmodule

// File: tb/tb_ht_ctrl.sv
// Self-checking bench for ht_ctrl: table-driven jobs, a sorting ht model and
// an output scoreboard, plus hand-written reset / spurious / timeout sequences.
module tb_ht_ctrl;

    localparam int IDX = 8;
    localparam int W   = 5;
`ifdef HT_CTRL_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic             out_ready = 1'b1;
    logic             ht_start;
    logic [IDX*W-1:0] ht_indata;
    logic [IDX*W-1:0] ht_outdata = '0;
    logic             ht_over;
    logic             busy;
    logic [15:0]      job_cnt;
    logic             err;

    always #5 clk = ~clk;

    ht_ctrl #(.index(IDX), .width(W), .timeout(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .ht_start   (ht_start),
        .ht_indata  (ht_indata),
        .ht_outdata (ht_outdata),
        .ht_over    (ht_over),
        .busy       (busy),
        .job_cnt    (job_cnt),
        .err        (err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        logic [W-1:0] din  [IDX];
        logic [W-1:0] dout [IDX];
        bit           gap;
        bit           bp;
    } vec_t;

    vec_t         tbl [4];
    logic [W-1:0] sb [$];
    bit           bp_mode = 1'b0;
    int           exp_jobs = 0;

    // ht model: sorted result, ht_over 10 cycles after ht_start
    logic         model_en = 1'b1;
    logic         model_over = 1'b0;
    logic         spur_over = 1'b0;
    logic [W-1:0] mv [IDX];
    logic [W-1:0] tmp;

    assign ht_over = model_over | spur_over;

    initial forever begin
        @(negedge clk);
        if (ht_start && model_en) begin
            for (int a = 0; a < IDX; a++) mv[a] = ht_indata[a*W +: W];
            for (int a = 0; a < IDX - 1; a++)
                for (int b = 0; b < IDX - 1 - a; b++)
                    if (mv[b] > mv[b+1]) begin
                        tmp = mv[b]; mv[b] = mv[b+1]; mv[b+1] = tmp;
                    end
            repeat (10) @(negedge clk);
            for (int a = 0; a < IDX; a++) ht_outdata[a*W +: W] = mv[a];
            model_over = 1'b1;
            @(negedge clk);
            model_over = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 out_ready = bp_mode ? ~out_ready : 1'b1;
    end

    // Output monitor: scoreboard pop, stall stability, in_ready while busy
    int           out_idx = 0;
    bit           stalled = 1'b0;
    logic [W-1:0] held;
    logic [W-1:0] expv;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            stalled = 1'b0;
            out_idx = 0;
        end else begin
            if (busy) chk("in_ready_while_busy", in_ready, 1'b0);
            if (out_valid) begin
                if (stalled) chk("stall_hold", out_data, held);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", out_data, 64'hDEAD);
                    end else begin
                        expv = sb.pop_front();
                        chk("out_data", out_data, expv);
                        chk("out_last", out_last, (out_idx == IDX - 1));
                    end
                    out_idx = (out_idx == IDX - 1) ? 0 : out_idx + 1;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end
        end
    end

    function automatic logic [IDX*W-1:0] pack(input logic [W-1:0] d [IDX]);
        logic [IDX*W-1:0] p;
        for (int k = 0; k < IDX; k++) p[k*W +: W] = d[k];
        return p;
    endfunction

    task automatic run_job(input int t, input bit spur_start);
        int i = 0;
        int g = 0;
        bit ph = 1'b0;
        for (int k = 0; k < IDX; k++) sb.push_back(tbl[t].dout[k]);
        bp_mode = tbl[t].bp;
        while (i < IDX && g < 100) begin
            @(posedge clk); #1;
            if (tbl[t].gap && ph) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = tbl[t].din[i];
            end
            ph = ~ph;
            @(negedge clk);
            if (in_valid && in_ready) i++;
            g++;
        end
        chk("load_count", i, IDX);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        if (spur_start) spur_over = 1'b1;
        @(negedge clk);
        chk("start_pulse", ht_start, 1'b1);
        chk("ht_indata", ht_indata, pack(tbl[t].din));
        @(posedge clk); #1;
        spur_over = 1'b0;
        @(negedge clk);
        chk("start_single", ht_start, 1'b0);
        chk("run_busy", busy, 1'b1);
        chk("run_no_output", out_valid, 1'b0);
        chk("ht_indata_held", ht_indata, pack(tbl[t].din));
    endtask

    task automatic wait_done();
        int g = 0;
        while ((sb.size() != 0 || busy) && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("job_complete", (sb.size() == 0 && !busy), 1'b1);
        bp_mode = 1'b0;
        exp_jobs++;
        chk("job_cnt", job_cnt, exp_jobs);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("in_ready_in_rst", in_ready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        exp_jobs = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        tbl[0].din  = '{5'h1F, 5'h03, 5'h10, 5'h00, 5'h07, 5'h1A, 5'h02, 5'h09};
        tbl[0].dout = '{5'h00, 5'h02, 5'h03, 5'h07, 5'h09, 5'h10, 5'h1A, 5'h1F};
        tbl[0].gap  = 1'b0; tbl[0].bp = 1'b0;
        tbl[1].din  = '{5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00, 5'h1F, 5'h1E};
        tbl[1].dout = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h1E, 5'h1F};
        tbl[1].gap  = 1'b0; tbl[1].bp = 1'b1;
        tbl[2].din  = '{5'h11, 5'h0A, 5'h0A, 5'h1C, 5'h06, 5'h13, 5'h00, 5'h08};
        tbl[2].dout = '{5'h00, 5'h06, 5'h08, 5'h0A, 5'h0A, 5'h11, 5'h13, 5'h1C};
        tbl[2].gap  = 1'b1; tbl[2].bp = 1'b0;
        tbl[3].din  = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
        tbl[3].dout = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
        tbl[3].gap  = 1'b1; tbl[3].bp = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_ht_start", ht_start, 1'b0);
        chk("rst_job_cnt", job_cnt, 16'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_ht_indata", ht_indata, '0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);

        for (int t = 0; t < 4; t++) begin
            run_job(t, 1'b0);
            wait_done();
        end

        // spurious ht_over in LOAD, then in START
        @(posedge clk); #1 spur_over = 1'b1;
        @(posedge clk); #1 spur_over = 1'b0;
        @(negedge clk);
        chk("spur_load_busy", busy, 1'b0);
        chk("spur_load_out_valid", out_valid, 1'b0);
        run_job(2, 1'b1);
        wait_done();

        // reset while in RUN; the model's late ht_over must be ignored
        run_job(0, 1'b0);
        repeat (2) @(negedge clk);
        pulse_rst();
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_job_cnt", job_cnt, 16'd0);
        repeat (15) begin
            @(negedge clk);
            chk("late_over_ignored", {busy, out_valid}, 2'b00);
        end
        run_job(1, 1'b0);
        wait_done();

`ifdef HT_CTRL_TIMEOUT_EN
        model_en = 1'b0;
        run_job(3, 1'b0);
        repeat (15) @(negedge clk);
        chk("wdog_not_yet_busy", busy, 1'b1);
        chk("wdog_not_yet_err", err, 1'b0);
        @(negedge clk);
        chk("wdog_load", busy, 1'b0);
        chk("wdog_err", err, 1'b1);
        chk("wdog_job_cnt", job_cnt, exp_jobs);
        chk("wdog_out_valid", out_valid, 1'b0);
        sb.delete();
        bp_mode  = 1'b0;
        model_en = 1'b1;
        run_job(0, 1'b0);
        wait_done();
        chk("err_sticky", err, 1'b1);
`else
        model_en = 1'b0;
        run_job(3, 1'b0);
        repeat (40) @(negedge clk);
        chk("no_wdog_busy", busy, 1'b1);
        chk("no_wdog_err", err, 1'b0);
        bp_mode = 1'b0;
        pulse_rst();
        model_en = 1'b1;
        run_job(0, 1'b0);
        wait_done();
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
